// File: rtl/sms_osc_timing_ring.sv
// sms_osc_timing_ring
//   Receives the 1 MHz SMS oscillator line, brings it into the clk domain,
//   measures each pulse's period and high time, and steps a one-hot timing
//   ring that produces the memory-cycle timing gates. A dead, fast, slow or
//   malformed oscillator is latched as a sticky fault.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   osc_in       oscillator line, asynchronous to clk
//   run          level; request continuous memory cycles
//   fault_clr    one-clk pulse; clears a sticky fault (only in FAULT)
//   gate         one-hot timing gates, gate[k] high from pulse k to pulse k+1
//   cycle_start  one-clk pulse when the ring enters position 0
//   locked       oscillator qualified
//   busy         ring active
//   fault        sticky fault
//   fault_code   01 slow/dead, 10 fast, 11 bad width, 00 no fault
module sms_osc_timing_ring #(
  parameter int unsigned RING_LEN   = 20,
  parameter int unsigned PERIOD_MIN = 90,
  parameter int unsigned PERIOD_MAX = 110,
  parameter int unsigned WIDTH_MIN  = 10,
  parameter int unsigned WIDTH_MAX  = 40,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CW         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                osc_in,
  input  logic                run,
  input  logic                fault_clr,
  output logic [RING_LEN-1:0] gate,
  output logic                cycle_start,
  output logic                locked,
  output logic                busy,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0]       ONE       = CW'(1);
  localparam logic [CW-1:0]       P_MIN     = CW'(PERIOD_MIN);
  localparam logic [CW-1:0]       P_MAX     = CW'(PERIOD_MAX);
  localparam logic [CW-1:0]       W_MIN     = CW'(WIDTH_MIN);
  localparam logic [CW-1:0]       W_MAX     = CW'(WIDTH_MAX);
  localparam logic [GW-1:0]       LOCK_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [RING_LEN-1:0] GATE0     = {{(RING_LEN-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCKING,
    S_READY,
    S_RUN,
    S_FAULT
  } state_t;

  state_t              state_q;
  logic                s1_q, s2_q, s3_q;
  logic [CW-1:0]       per_q, per_d;
  logic [CW-1:0]       hi_q, hi_d;
  logic [GW-1:0]       good_q;
  logic [RING_LEN-1:0] gate_q;
  logic                cs_q, locked_q, busy_q, fault_q;
  logic [1:0]          code_q, code_d;

  logic rise, fall, checking;
  logic err_slow, err_fast, err_width, err_any;

  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;

    // Both counters saturate so a stalled line cannot wrap back into range.
    per_d = rise ? ONE : ((per_q == '1) ? per_q : per_q + 1'b1);

    hi_d = hi_q;
    if (rise) begin
      hi_d = ONE;
    end else if (s2_q && (hi_q != '1)) begin
      hi_d = hi_q + 1'b1;
    end

    // Checks are live only once a reference rise has started timing.
    checking  = (state_q == S_LOCKING) || (state_q == S_READY) || (state_q == S_RUN);
    // per_q beyond PERIOD_MAX catches both a late rise and a dead line.
    err_slow  = checking && (per_q > P_MAX);
    err_fast  = checking && rise && (per_q < P_MIN);
    err_width = checking && fall && ((hi_q < W_MIN) || (hi_q > W_MAX));

    code_d = 2'b00;
    if (err_slow) begin
      code_d = 2'b01;
    end else if (err_fast) begin
      code_d = 2'b10;
    end else if (err_width) begin
      code_d = 2'b11;
    end
    err_any = (code_d != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      per_q    <= '0;
      hi_q     <= '0;
      good_q   <= '0;
      gate_q   <= '0;
      cs_q     <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      s1_q  <= osc_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      per_q <= per_d;
      hi_q  <= hi_d;
      cs_q  <= 1'b0;

      // An error wins over any ring advance on the same pulse.
      if (err_any) begin
        state_q  <= S_FAULT;
        gate_q   <= '0;
        busy_q   <= 1'b0;
        locked_q <= 1'b0;
        fault_q  <= 1'b1;
        code_q   <= code_d;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (rise) begin
              state_q <= S_LOCKING;
              good_q  <= '0;
            end
          end
          S_LOCKING: begin
            if (rise) begin
              if (good_q == LOCK_LAST) begin
                locked_q <= 1'b1;
                state_q  <= S_READY;
              end else begin
                good_q <= good_q + 1'b1;
              end
            end
          end
          S_READY: begin
            if (rise && run) begin
              gate_q  <= GATE0;
              cs_q    <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (rise) begin
              if (gate_q[RING_LEN-1]) begin
                if (run) begin
                  gate_q <= GATE0;
                  cs_q   <= 1'b1;
                end else begin
                  gate_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_READY;
                end
              end else begin
                gate_q <= gate_q << 1;
              end
            end
          end
          S_FAULT: begin
            if (fault_clr) begin
              fault_q <= 1'b0;
              code_q  <= '0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign gate        = gate_q;
  assign cycle_start = cs_q;
  assign locked      = locked_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_sms_osc_timing_ring.sv
// tb_sms_osc_timing_ring
//   Drives clock-aligned oscillator pulses with random legal period/width
//   plus directed boundary and error pulses, and compares the DUT against a
//   pulse-level reference model (one update per oscillator edge).
module tb_sms_osc_timing_ring;

  localparam int RING_LEN = 20;
  localparam int PMIN     = 90;
  localparam int PMAX     = 110;
  localparam int WMIN     = 10;
  localparam int WMAX     = 40;
  localparam int LOCKN    = 4;
  localparam int LAT      = 3;   // pin edge to registered output, in clk

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                osc_in = 1'b0;
  logic                run = 1'b0;
  logic                fault_clr = 1'b0;
  logic [RING_LEN-1:0] gate;
  logic                cycle_start, locked, busy, fault;
  logic [1:0]          fault_code;

  always #5 clk = ~clk;

  sms_osc_timing_ring #(
    .RING_LEN(RING_LEN), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
    .WIDTH_MIN(WMIN), .WIDTH_MAX(WMAX), .LOCK_COUNT(LOCKN), .CW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .run(run),
    .fault_clr(fault_clr), .gate(gate), .cycle_start(cycle_start),
    .locked(locked), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  typedef enum int {M_IDLE, M_LOCK, M_READY, M_RUN, M_FAULT} mstate_t;
  mstate_t m_st = M_IDLE;
  int m_good = 0;
  int m_pos = 0;
  int m_code = 0;
  bit m_cs = 1'b0;
  int since = 1000;     // clk since the last pin rise
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_gate();
    return (m_st == M_RUN) ? (32'd1 << m_pos) : 32'd0;
  endfunction

  task automatic check_all(input string w, input bit cs_exp);
    chk({w, ".gate"},        32'(gate),        exp_gate());
    chk({w, ".cycle_start"}, 32'(cycle_start), 32'(cs_exp));
    chk({w, ".locked"},      32'(locked),      32'(m_st == M_READY || m_st == M_RUN));
    chk({w, ".busy"},        32'(busy),        32'(m_st == M_RUN));
    chk({w, ".fault"},       32'(fault),       32'(m_st == M_FAULT));
    chk({w, ".fault_code"},  32'(fault_code),  32'(m_code));
  endtask

  function automatic bit m_active();
    return (m_st == M_LOCK) || (m_st == M_READY) || (m_st == M_RUN);
  endfunction

  task automatic m_fault(input int c);
    if (m_active()) begin
      m_st   = M_FAULT;
      m_code = c;
    end
  endtask

  task automatic m_rise(input int p);
    m_cs = 1'b0;
    if (m_st == M_IDLE) begin
      m_st   = M_LOCK;
      m_good = 0;
    end else if (m_active() && p < PMIN) begin
      m_fault(2);
    end else if (m_active() && p > PMAX) begin
      m_fault(1);
    end else if (m_st == M_LOCK) begin
      m_good++;
      if (m_good == LOCKN) m_st = M_READY;
    end else if (m_st == M_READY) begin
      if (run) begin
        m_st = M_RUN; m_pos = 0; m_cs = 1'b1;
      end
    end else if (m_st == M_RUN) begin
      if (m_pos == RING_LEN - 1) begin
        if (run) begin
          m_pos = 0; m_cs = 1'b1;
        end else begin
          m_st = M_READY;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
    if (since == LAT + PMAX + 1) m_fault(1);
  endtask

  // One oscillator pulse of period p and high time h, starting now.
  task automatic pulse(input int p, input int h, input bit clr);
    int pp;
    osc_in = 1'b1;
    fault_clr = clr;
    pp = since;
    since = 0;
    tick();
    fault_clr = 1'b0;
    if (clr && m_st == M_FAULT) begin
      m_st = M_IDLE; m_code = 0;
    end
    tick();
    tick();
    m_rise(pp);
    check_all("rise", m_cs);
    repeat (h - 3) tick();
    osc_in = 1'b0;
    repeat (3) tick();
    if (h < WMIN || h > WMAX) m_fault(3);
    check_all("fall", 1'b0);
    repeat (p - h - 3) tick();
  endtask

  task automatic rnd_pulse();
    int p, h;
    p = int'($urandom_range(PMAX, PMIN));
    h = int'($urandom_range(WMAX, WMIN));
    pulse(p, h, 1'b0);
  endtask

  task automatic silence(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all("silence", 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    m_st = M_IDLE; m_code = 0; m_cs = 1'b0;
    check_all("reset", 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset_init", 1'b0);
    end
    rst_n = 1'b1;

    // Lock with run low: locked appears on the 5th rise
    for (int i = 0; i < 5; i++) rnd_pulse();
    chk("locked_after_5", 32'(locked), 32'd1);

    // Continuous cycles
    run = 1'b1;
    for (int i = 0; i < 45; i++) rnd_pulse();

    // Drop run while gate[7] is high; ring completes the cycle
    n = 0;
    while (!(m_st == M_RUN && m_pos == 7) && n < 40) begin
      rnd_pulse();
      n++;
    end
    chk("reached_gate7", 32'(gate), 32'h80);
    run = 1'b0;
    for (int i = 0; i < 14; i++) rnd_pulse();
    run = 1'b1;
    rnd_pulse();

    // Inclusive period and width bounds
    pulse(PMIN, WMIN, 1'b0);
    pulse(PMAX, WMAX, 1'b0);
    pulse(PMIN, WMAX, 1'b0);
    pulse(PMAX, WMIN, 1'b0);

    // fault_clr without a fault is ignored
    pulse(100, 20, 1'b1);

    // Fast period; later width error keeps the first code
    pulse(80, 20, 1'b0);
    pulse(100, 50, 1'b0);
    pulse(100, 20, 1'b0);

    // Recovery and re-lock
    pulse(100, 20, 1'b1);
    for (int i = 0; i < 4; i++) rnd_pulse();
    for (int i = 0; i < 3; i++) rnd_pulse();

    // Over-wide high time
    pulse(100, 50, 1'b0);
    pulse(100, 20, 1'b1);
    for (int i = 0; i < 6; i++) rnd_pulse();

    // Dead oscillator
    silence(30);
    pulse(100, 20, 1'b1);
    for (int i = 0; i < 4; i++) rnd_pulse();

    // Reset mid-cycle at gate[12]
    n = 0;
    while (!(m_st == M_RUN && m_pos == 12) && n < 40) begin
      rnd_pulse();
      n++;
    end
    chk("reached_gate12", 32'(gate), 32'h1000);
    do_reset();
    for (int i = 0; i < 7; i++) rnd_pulse();

    // Too narrow high time
    pulse(100, WMIN - 1, 1'b0);
    pulse(100, 20, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sms_osc_timing_ring.md
Name: sms_osc_timing_ring

Overview:
- Receiving end of the 1 MHz SMS oscillator card output: samples the oscillator line in the simulation clock domain, qualifies each pulse for period and width, and advances a one-hot timing ring that produces the memory-cycle timing gates.
- Sits between the oscillator card model and the cycle-control logic.
- Flags a dead, fast, slow or malformed oscillator as a sticky fault.

Parameters:
- RING_LEN, 20, number of ring positions (oscillator pulses per memory cycle).
- PERIOD_MIN, 90, minimum legal clk cycles between osc rising edges.
- PERIOD_MAX, 110, maximum legal clk cycles between osc rising edges; also the dead-oscillator timeout.
- WIDTH_MIN, 10, minimum legal high time in clk cycles.
- WIDTH_MAX, 40, maximum legal high time in clk cycles.
- LOCK_COUNT, 4, consecutive good periods required before the ring may run.
- CW, 8, measurement counter width; counters saturate at 2^CW-1.

Ports:
- clk  in  1  system simulation clock (nominal 100 MHz; oscillator period is 100 clk).
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- osc_in  in  1  oscillator line (card pin D), asynchronous to clk.
- run  in  1  level; request continuous memory cycles.
- fault_clr  in  1  one-clk pulse; clears a sticky fault.
- gate  out  RING_LEN  one-hot timing gates; gate[k] is high from qualified pulse k until pulse k+1.
- cycle_start  out  1  one-clk pulse when the ring enters position 0.
- locked  out  1  oscillator qualified.
- busy  out  1  ring active.
- fault  out  1  sticky fault.
- fault_code  out  2  01 slow/dead, 10 fast, 11 bad width; 00 when no fault.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, counters 0, synchronizer flops 0. This applies mid-cycle too, with no completion of the current cycle.
- Input conditioning: osc_in passes through 2 flops (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from osc_in edge to rise/fall is 2-3 clk.
- Measurement counters:
  - per_cnt clears to 1 on rise and otherwise increments (saturating).
  - hi_cnt clears to 1 on rise, increments while s2=1, and is frozen at fall.
- Qualification:
  - On each fall: hi_cnt outside [WIDTH_MIN, WIDTH_MAX] is a width error.
  - On each rise after the first: per_cnt < PERIOD_MIN is a fast error; per_cnt > PERIOD_MAX is a slow error.
  - per_cnt reaching PERIOD_MAX+1 with no rise is a slow error (dead oscillator), detected without waiting for an edge.
  - The first rise after IDLE is reference only: it starts timing and is not checked.
- States:
  - IDLE: wait for the first rise, then go to LOCKING with good_cnt=0.
  - LOCKING: each good rise increments good_cnt. At good_cnt==LOCK_COUNT, locked=1 and go to READY. Any error goes to FAULT.
  - READY: locked=1. On a rise with run=1: gate=1<<0, cycle_start=1 for that clk, busy=1, go to RUN.
  - RUN: each good rise rotates gate left by 1. From gate[RING_LEN-1]:
    - if run=1, wrap to gate[0] and pulse cycle_start;
    - if run=0, clear gate, busy=0, go to READY.
    - Deasserting run mid-cycle always completes the current cycle.
  - FAULT: gate=0, busy=0, locked=0, fault=1, and fault_code holds the first error class. Simultaneous classes in the same clk resolve by priority 01 > 10 > 11. Later errors do not change the code.
  - fault_clr in FAULT: clear fault/fault_code and go to IDLE. fault_clr in any other state is ignored.
- Update timing: the gate update, cycle_start and error detection occur in the same clk that rise/fall is seen, with outputs registered. gate changes one clk after the rise is seen.
- Errors in READY or RUN go to FAULT immediately, dropping the gates without completing the cycle.
- A pulse that is both rise-qualified and triggers a fault (e.g. a fast period) does not advance the ring.
- Width and period checks use inclusive bounds: per_cnt==PERIOD_MIN and per_cnt==PERIOD_MAX are legal.

Test Plan:
- Nominal: osc 100-clk period / 20-clk high, run=1 after locked -> locked rises on the 5th rise; each cycle is 2000 clk; cycle_start every 2000 clk; exactly one gate bit high at all times while busy.
- Run drop: deassert run while gate[7] is high -> ring continues to gate[19], then gate=0, busy=0, locked stays 1; re-assert run -> restart at gate[0] on the next rise.
- Dead oscillator: hold osc_in low after lock -> fault=1, fault_code=01 within 111 clk of the last rise (plus sync latency); gate=0.
- Fast/width errors: one period of 80 clk -> fault_code=10. Separately, a 50-clk high time -> fault_code=11. Boundary periods of 90 and 110 clk -> no fault.
- Recovery: fault_clr while faulted with a good oscillator -> IDLE, re-lock after 5 rises. fault_clr with no fault -> no effect.
- Reset mid-RUN at gate[12] -> next clk all outputs 0; after release, the full lock sequence is required before gates reappear.
